my_axi_lite_m_seq: RTL and testbench

AXI4-Lite master sequencer that sits directly upstream of the `my_axi_lite_s` slave register block and drives its S00_AXI port. On a start pulse it writes a run of sequential words to consecutive slave registers, reads them back, and compares each read against the value written. It reports completion and a sticky error flag. This gives an in-fabric self-test for the slave without the VIP master.

---
 rtl/my_axi_lite_m_seq.sv | 219 +++++++++++++++++++++
 tb/tb_my_axi_lite_m_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/my_axi_lite_m_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// my_axi_lite_m_seq: AXI4-Lite write/readback self-test sequencer.
// Optional watchdog enabled by defining MY_AXI_LITE_M_TIMEOUT_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
module my_axi_lite_m_seq #(
    parameter C_M_TARGET_BASE_ADDR = 32'h0000_0000,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_TRANSACTIONS_NUM = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              INIT_TXN,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     START_DATA,
    output logic                              TXN_DONE,
    output logic                              BUSY,
    output logic                              ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int IDX_W = (C_M_TRANSACTIONS_NUM > 1) ? $clog2(C_M_TRANSACTIONS_NUM) : 1;
    localparam logic [AW-1:0]    BASE = AW'(C_M_TARGET_BASE_ADDR);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(C_M_TRANSACTIONS_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    seed;
    logic             init_q;
    logic             aw_done;
    logic             w_done;
    logic             wr_both;

    function automatic logic [AW-1:0] addr_of(input logic [IDX_W-1:0] i);
        return BASE + (AW'(i) << 2);
    endfunction

    function automatic logic [DW-1:0] data_of(input logic [DW-1:0] s, input logic [IDX_W-1:0] i);
        return s + DW'(i);
    endfunction

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // AW and W complete independently; both must be done, possibly in this cycle.
    assign wr_both = (aw_done || (M_AXI_AWVALID && M_AXI_AWREADY)) &&
                     (w_done  || (M_AXI_WVALID  && M_AXI_WREADY));

`ifdef MY_AXI_LITE_M_TIMEOUT_EN
    logic [7:0] wd;
    logic       leave;

    assign leave = (state == S_WR_REQ  && wr_both) ||
                   (state == S_WR_RESP && M_AXI_BVALID) ||
                   (state == S_RD_REQ  && M_AXI_ARREADY) ||
                   (state == S_RD_RESP && M_AXI_RVALID);

    always_ff @(posedge ACLK) begin
        if (ARESET || leave || state == S_IDLE || state == S_DONE)
            wd <= '0;
        else if (wd != 8'hFF)
            wd <= wd + 8'd1;
    end
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            idx           <= '0;
            seed          <= '0;
            init_q        <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            TXN_DONE      <= 1'b0;
            BUSY          <= 1'b0;
            ERROR         <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            init_q <= INIT_TXN;
`ifdef MY_AXI_LITE_M_TIMEOUT_EN
            if (wd == 8'hFF) begin
                ERROR         <= 1'b1;
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                TXN_DONE      <= 1'b1;
                state         <= S_DONE;
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        TXN_DONE <= 1'b0;
                        if (INIT_TXN && !init_q) begin
                            seed          <= START_DATA;
                            idx           <= '0;
                            ERROR         <= 1'b0;
                            BUSY          <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            M_AXI_AWADDR  <= addr_of('0);
                            M_AXI_WDATA   <= START_DATA;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WR_REQ;
                        end
                    end
                    S_WR_REQ: begin
                        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                            M_AXI_AWVALID <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (M_AXI_WVALID && M_AXI_WREADY) begin
                            M_AXI_WVALID <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        if (wr_both) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= S_WR_RESP;
                        end
                    end
                    S_WR_RESP: begin
                        if (M_AXI_BVALID) begin
                            M_AXI_BREADY <= 1'b0;
                            if (M_AXI_BRESP != 2'b00)
                                ERROR <= 1'b1;
                            if (idx == LAST) begin
                                idx           <= '0;
                                M_AXI_ARADDR  <= addr_of('0);
                                M_AXI_ARVALID <= 1'b1;
                                state         <= S_RD_REQ;
                            end else begin
                                idx           <= idx + 1'b1;
                                aw_done       <= 1'b0;
                                w_done        <= 1'b0;
                                M_AXI_AWADDR  <= addr_of(idx + 1'b1);
                                M_AXI_WDATA   <= data_of(seed, idx + 1'b1);
                                M_AXI_AWVALID <= 1'b1;
                                M_AXI_WVALID  <= 1'b1;
                                state         <= S_WR_REQ;
                            end
                        end
                    end
                    S_RD_REQ: begin
                        if (M_AXI_ARREADY) begin
                            M_AXI_ARVALID <= 1'b0;
                            M_AXI_RREADY  <= 1'b1;
                            state         <= S_RD_RESP;
                        end
                    end
                    S_RD_RESP: begin
                        if (M_AXI_RVALID) begin
                            M_AXI_RREADY <= 1'b0;
                            if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != data_of(seed, idx))
                                ERROR <= 1'b1;
                            if (idx == LAST) begin
                                TXN_DONE <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                idx           <= idx + 1'b1;
                                M_AXI_ARADDR  <= addr_of(idx + 1'b1);
                                M_AXI_ARVALID <= 1'b1;
                                state         <= S_RD_REQ;
                            end
                        end
                    end
                    S_DONE: begin
                        TXN_DONE <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_my_axi_lite_m_seq.sv
`default_nettype none
`timescale 1ns/1ps
//----------------------------------------------------------------------------
// tb_my_axi_lite_m_seq: scoreboard bench with a behavioural AXI4-Lite slave.
// Revision: 1.0
//----------------------------------------------------------------------------
module tb_my_axi_lite_m_seq;

    localparam int N = 4;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_txn = 1'b0;
    logic [31:0] start_data = '0;
    logic        txn_done, busy, error;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    my_axi_lite_m_seq #(
        .C_M_TARGET_BASE_ADDR(BASE),
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_TRANSACTIONS_NUM(N)
    ) dut (
        .ACLK(clk), .ARESET(rst), .INIT_TXN(init_txn), .START_DATA(start_data),
        .TXN_DONE(txn_done), .BUSY(busy), .ERROR(error),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Slave configuration and scoreboard queues
    int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    bit          aw_block = 0;
    logic [31:0] bresp_err_addr = NONE, rd_corrupt_addr = NONE;
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
    logic [31:0] mem [0:15];
    bit          b_pend = 0, r_pend = 0;
    int          wr_resp_cnt = 0, done_cnt = 0;

    // Ready/valid are changed on the falling edge, so a handshake observed here
    // completes on the following rising edge.
    always @(negedge clk) begin
        logic [31:0] a, d;
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_q.delete(); w_q.delete(); ar_q.delete();
            exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
            b_pend = 0; r_pend = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (txn_done) done_cnt++;
            if (b_pend) begin bvalid = 0; b_pend = 0; wr_resp_cnt++; end
            if (!bvalid && aw_q.size() > 0 && w_q.size() > 0) begin
                a = aw_q.pop_front();
                d = w_q.pop_front();
                check("wr_expected", 32'(exp_wa.size() > 0), 32'd1);
                if (exp_wa.size() > 0) begin
                    check("wr_addr", a, exp_wa.pop_front());
                    check("wr_data", d, exp_wd.pop_front());
                end
                mem[a[5:2]] = d;
                bresp  = (a == bresp_err_addr) ? 2'b10 : 2'b00;
                bvalid = 1;
            end
            if (bvalid && bready) b_pend = 1;

            if (r_pend) begin rvalid = 0; r_pend = 0; end
            if (!rvalid && ar_q.size() > 0) begin
                a = ar_q.pop_front();
                rdata  = (a == rd_corrupt_addr) ? 32'hDEAD_BEEF : mem[a[5:2]];
                rresp  = 2'b00;
                rvalid = 1;
            end
            if (rvalid && rready) r_pend = 1;

            awready = 0;
            if (awvalid) begin
                if (!aw_block && aw_wait >= aw_delay) begin
                    awready = 1; aw_q.push_back(awaddr); aw_wait = 0;
                end else aw_wait++;
            end
            wready = 0;
            if (wvalid) begin
                if (w_wait >= w_delay) begin
                    wready = 1; w_q.push_back(wdata); w_wait = 0;
                end else w_wait++;
            end
            arready = 0;
            if (arvalid) begin
                arready = 1;
                check("rd_after_writes", 32'(exp_wa.size()), 32'd0);
                check("rd_expected", 32'(exp_ra.size() > 0), 32'd1);
                if (exp_ra.size() > 0) check("rd_addr", araddr, exp_ra.pop_front());
                ar_q.push_back(araddr);
            end
        end
    end

    task automatic push_expect(input logic [31:0] sd);
        for (int i = 0; i < N; i++) begin
            exp_wa.push_back(BASE + 32'(4 * i));
            exp_wd.push_back(sd + 32'(i));
            exp_ra.push_back(BASE + 32'(4 * i));
        end
    endtask

    task automatic start(input logic [31:0] sd);
        push_expect(sd);
        done_cnt = 0;
        wr_resp_cnt = 0;
        @(negedge clk);
        start_data = sd;
        init_txn = 1;
        @(negedge clk);
        init_txn = 0;
        check("busy_start", 32'(busy), 32'd1);
        check("err_cleared", 32'(error), 32'd0);
    endtask

    task automatic run(input logic [31:0] sd, input logic exp_err);
        int n;
        start(sd);
        n = 0;
        while (!txn_done && n < 2000) begin @(negedge clk); n++; end
        check("done_in_time", 32'(n < 2000), 32'd1);
        check("err_at_done", 32'(error), 32'(exp_err));
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("wr_left", 32'(exp_wa.size()), 32'd0);
        check("rd_left", 32'(exp_ra.size()), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(txn_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("wstrb", 32'(wstrb), 32'hF);
        check("prot", {26'd0, awprot, arprot}, 32'd0);
        rst = 0;

        run(32'd1, 1'b0);
        for (int i = 0; i < N; i++) check("mem", mem[i], 32'(i + 1));

        aw_delay = 5; w_delay = 4;
        run(32'h100, 1'b0);
        aw_delay = 0; w_delay = 0;

        bresp_err_addr = 32'h8;
        run(32'h55, 1'b1);
        bresp_err_addr = NONE;
        run(32'h77, 1'b0);

        rd_corrupt_addr = 32'h4;
        run(32'hA0, 1'b1);
        rd_corrupt_addr = NONE;

        run(32'hFFFF_FFFE, 1'b0);
        check("wrap_mem2", mem[2], 32'h0);

        // Reset during the third write response
        start(32'h300);
        n = 0;
        while (!(wr_resp_cnt == 2 && bready) && n < 200) begin @(negedge clk); n++; end
        check("reach_wr3", 32'(n < 200), 32'd1);
        rst = 1;
        @(posedge clk); #1;
        check("abort_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(txn_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        run(32'h10, 1'b0);

        // AWREADY never arrives
        aw_block = 1;
        start(32'h20);
`ifdef MY_AXI_LITE_M_TIMEOUT_EN
        n = 0;
        while (!txn_done && n < 400) begin @(negedge clk); n++; end
        check("timeout_done", 32'(n < 400), 32'd1);
        check("timeout_err", 32'(error), 32'd1);
`else
        repeat (300) @(negedge clk);
        check("hang_busy", 32'(busy), 32'd1);
        check("hang_no_done", 32'(done_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
